// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Sequential instruction fetch front end. It issues word fetches to a
//   registered instruction ROM, collects the returning words in a 2-entry
//   {inst, pc} queue and presents the queue head through a valid/ready
//   handshake. A redirect flushes the queue, drops any in-flight word and
//   restarts fetch from the new target in the same cycle.
//
//   Optional feature (macro FETCH_PERF_CNT_EN): adds the stall_cycles output,
//   a saturating count of out-of-reset cycles with no valid head instruction.
//
// Parameters
//   ADDR_W    ROM word-address width (default 6 -> 64-word ROM)
//   RESET_PC  byte PC loaded on reset
//
// Ports
//   clk             single clock, rising-edge
//   reset           asynchronous, active-low reset
//   rom_addr        ROM word address (pc[ADDR_W+1:2] of the issued fetch)
//   rom_q           ROM data, valid the cycle after its address was presented
//   redirect_valid  one-cycle redirect strobe
//   redirect_pc     redirect target byte address (bits [1:0] ignored)
//   inst_valid      queue head holds a valid instruction
//   inst_ready      consumer accepts the head this cycle
//   inst            head instruction word
//   inst_pc         byte PC of the head instruction
//   stall_cycles    (FETCH_PERF_CNT_EN only) saturating stall counter
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_q,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  // State
  logic [31:0]       fetch_pc_q,    fetch_pc_d;
  logic              inflight_q,    inflight_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  entry_t            fifo_q [2];
  entry_t            fifo_d [2];
  logic [1:0]        count_q,       count_d;
  logic [ADDR_W-1:0] addr_q;

  // Handshake / issue decode
  logic        pop;
  logic        issue;
  logic [1:0]  pending;
  logic [1:0]  base;
  logic [31:0] target;
  logic [31:0] issue_pc;

  assign inst_valid = (count_q != 2'd0);
  assign inst       = fifo_q[0].inst;
  assign inst_pc    = fifo_q[0].pc;
  assign pop        = inst_valid & inst_ready;

  // Slots that stay committed after this cycle's pop; a new fetch only goes
  // out when its returning word is guaranteed a free queue slot.
  assign pending  = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign target   = {redirect_pc[31:2], 2'b00};
  assign issue    = redirect_valid | (pending < 2'd2);
  assign issue_pc = redirect_valid ? target : fetch_pc_q;

  // The ROM registers the address itself, so the issued address must be
  // visible combinationally in the issue cycle; otherwise hold the last one.
  assign rom_addr = issue ? issue_pc[ADDR_W+1:2] : addr_q;

  // Queue occupancy after the pop, i.e. the slot the returning word fills.
  assign base = count_q - {1'b0, pop};

  // NOTE: every signal driven here gets a default first so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    fifo_d        = fifo_q;
    count_d       = count_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    fetch_pc_d    = fetch_pc_q;

    if (issue) begin
      inflight_pc_d = issue_pc;
      fetch_pc_d    = issue_pc + 32'd4;
    end

    if (redirect_valid) begin
      // Flush wins over any pop/push this cycle; the word returning now
      // belongs to the old path and is dropped.
      count_d = 2'd0;
    end else begin
      if (pop) begin
        fifo_d[0] = fifo_q[1];
      end
      if (inflight_q) begin
        fifo_d[base[0]] = '{inst: rom_q, pc: inflight_pc_q};
      end
      count_d = base + {1'b0, inflight_q};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      count_q       <= 2'd0;
      addr_q        <= RESET_PC[ADDR_W+1:2];
      // NOTE: the queue storage is reset (not just the count) because the
      // head is driven straight onto inst/inst_pc, which must read zero in
      // reset.
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      addr_q        <= rom_addr;
      fifo_q[0]     <= fifo_d[0];
      fifo_q[1]     <= fifo_d[1];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'd0;
    end else if (!inst_valid && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit (default build, ADDR_W=6, RESET_PC=0).
//   A registered ROM model returns {16'hC0DE, 10'b0, addr} for word address
//   addr, so every expected word is known from its PC alone.
//   Inputs change 1 time unit after each rising edge; outputs are compared
//   1 time unit after that. "Cycle 0" is the first cycle with reset high.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int ADDR_W = 6;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_q;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_q          (rom_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, 10'd0, a};
  endfunction

  // Registered ROM: address seen at an edge is answered after that edge.
  always @(posedge clk) rom_q <= rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    check({tag, "_inst"},  inst, rom_word(pc[ADDR_W+1:2]));
    check({tag, "_pc"},    inst_pc, pc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    repeat (2) tick();
    settle();

    // Reset state
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst",  inst, 32'd0);
    check("rst_pc",    inst_pc, 32'd0);
    check("rst_addr",  {26'd0, rom_addr}, 32'd0);

    // Cycle 0: release reset, first fetch issues from RESET_PC
    tick();
    reset      = 1'b1;
    inst_ready = 1'b1;
    settle();
    check("c0_addr",  {26'd0, rom_addr}, 32'd0);
    check("c0_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    // Cycle 1: second fetch out, nothing queued yet
    check("c1_addr",  {26'd0, rom_addr}, 32'd1);
    check("c1_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    // Cycles 2..4: one instruction per cycle
    for (int k = 0; k < 3; k++) begin
      check_head("stream", 32'(k * 4));
      tick();
    end

    // Cycles 5..10: consumer stalls; head stable, no new fetch (addr of pc 16 held)
    inst_ready = 1'b0;
    settle();
    for (int i = 0; i < 6; i++) begin
      check_head("stall", 32'd12);
      check("stall_addr", {26'd0, rom_addr}, 32'd4);
      tick();
    end

    // Cycles 11..14: resume with no loss or duplication
    inst_ready = 1'b1;
    settle();
    for (int k = 3; k < 7; k++) begin
      check_head("resume", 32'(k * 4));
      tick();
    end

    // Cycles 15..16: stall again to fill the queue (pc 28, pc 32)
    inst_ready = 1'b0;
    settle();
    check_head("fill", 32'd28);
    tick();
    check_head("full", 32'd28);
    check("full_addr", {26'd0, rom_addr}, 32'd8);

    // Cycle 16: redirect to 0x43 with queue full -> fetch of 0x40 this cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    settle();
    check("rd_addr", {26'd0, rom_addr}, 32'd16);
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    settle();
    check("rd_flush", {31'd0, inst_valid}, 32'd0);
    tick();
    check_head("rd_first", 32'h40);
    tick();
    check_head("rd_next", 32'h44);

    // Cycle 19: redirect to 0xFC coincident with a transfer
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_00FC;
    settle();
    check("wrap_addr63", {26'd0, rom_addr}, 32'd63);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("xfer_flush", {31'd0, inst_valid}, 32'd0);
    check("wrap_addr0", {26'd0, rom_addr}, 32'd0);
    tick();
    check_head("wrap_fc", 32'h0000_00FC);
    tick();
    check_head("wrap_100", 32'h0000_0100);
    tick();
    check_head("wrap_104", 32'h0000_0104);

    // Cycle 23: PC wraps modulo 2^32; low target bits ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    settle();
    check("pcwrap_addr", {26'd0, rom_addr}, 32'd63);
    tick();
    redirect_valid = 1'b0;
    tick();
    check_head("pcwrap_top", 32'hFFFF_FFFC);
    tick();
    check_head("pcwrap_zero", 32'h0000_0000);

    // Mid-operation reset: queue and in-flight discarded at once
    reset = 1'b0;
    settle();
    check("mrst_valid", {31'd0, inst_valid}, 32'd0);
    check("mrst_inst",  inst, 32'd0);
    check("mrst_pc",    inst_pc, 32'd0);
    check("mrst_addr",  {26'd0, rom_addr}, 32'd0);
    tick();
    reset = 1'b1;
    settle();
    check("mrst_c0_addr", {26'd0, rom_addr}, 32'd0);
    check("mrst_c0_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    tick();
    check_head("mrst_first", 32'd0);
    tick();
    check_head("mrst_second", 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
